// File: rtl/chunk_input_buffer.sv
// chunk_input_buffer: ping-pong sample capture ahead of the chunk processor.
// One bank fills from the input stream while the other is read by pointer.
module chunk_input_buffer #(
   parameter int SAMPLE_SIZE      = 24,
   parameter int IO_BUFF_SIZE     = 64,
   parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [SAMPLE_SIZE-1:0]      in_sample,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        chunk_pulse,
   output logic                        read_bank,
   input  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
   output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
   input  logic                        chunk_release,
   output logic [15:0]                 chunk_count,
   output logic                        overrun
);

   localparam int ADDR_BITS = IO_BUFF_PTR_BITS + 1;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic                        r_wr_bank;
   logic [IO_BUFF_PTR_BITS-1:0] r_wr_ptr;
   logic [1:0]                  r_bank_full;
   logic                        r_read_bank;
   logic                        r_chunk_pulse;
   logic [15:0]                 r_chunk_count;
   logic                        r_overrun;
   logic [SAMPLE_SIZE-1:0]      r_rd_data;
   logic [SAMPLE_SIZE-1:0]      r_mem [2*IO_BUFF_SIZE];

   logic                        w_in_ready;
   logic                        w_accept;
   logic                        w_last;
   logic                        w_handover;
   logic                        w_release;
   logic                        w_new_bank;
   logic [1:0]                  w_bank_full_nxt;
   logic [ADDR_BITS-1:0]        w_wr_addr;
   logic [ADDR_BITS-1:0]        w_rd_addr;

   // Write-side handshake: a bank is writable until it is marked full.
   always_comb begin
      w_in_ready = !rst && !r_bank_full[r_wr_bank];
      w_accept   = in_valid && w_in_ready;
      w_last     = (r_wr_ptr == IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1));
      w_wr_addr  = {r_wr_bank, r_wr_ptr};
      w_rd_addr  = {r_read_bank, input_buff_ptr};
   end

   // Reader FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Reader FSM next-state: take a full bank, hold it until released.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (|r_bank_full) begin
               w_state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (chunk_release) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Reader FSM outputs: handover and release strobes for the datapath.
   always_comb begin
      w_handover = 1'b0;
      w_release  = 1'b0;
      // Only one bank can be full while idle, so bank 1 full picks bank 1.
      w_new_bank = r_bank_full[1];
      unique case (r_state)
         S_IDLE:   w_handover = |r_bank_full;
         S_ACTIVE: w_release  = chunk_release;
         default: ;
      endcase
   end

   // Full flags: set by the last write of a bank, cleared by its release.
   always_comb begin
      w_bank_full_nxt = r_bank_full;
      if (w_accept && w_last) begin
         w_bank_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_release) begin
         w_bank_full_nxt[r_read_bank] = 1'b0;
      end
   end

   // Write pointer, write bank and full flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_bank   <= 1'b0;
         r_wr_ptr    <= '0;
         r_bank_full <= 2'b00;
      end else begin
         r_bank_full <= w_bank_full_nxt;
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + IO_BUFF_PTR_BITS'(1);
            if (w_last) begin
               r_wr_bank <= ~r_wr_bank;
            end
         end
      end
   end

   // Handover bookkeeping: owned bank, one-cycle pulse, chunk counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_read_bank   <= 1'b0;
         r_chunk_pulse <= 1'b0;
         r_chunk_count <= 16'd0;
      end else begin
         r_chunk_pulse <= w_handover;
         if (w_handover) begin
            r_read_bank   <= w_new_bank;
            r_chunk_count <= r_chunk_count + 16'd1;
         end
      end
   end

   // Sticky overrun: a sample was offered while no bank could take it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (in_valid && !w_in_ready) begin
         r_overrun <= 1'b1;
      end
   end

   // Sample storage; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[w_wr_addr] <= in_sample;
      end
   end

   // Registered read port, active regardless of FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[w_rd_addr];
      end
   end

   assign in_ready          = w_in_ready;
   assign chunk_pulse       = r_chunk_pulse;
   assign read_bank         = r_read_bank;
   assign input_buff_sample = r_rd_data;
   assign chunk_count       = r_chunk_count;
   assign overrun           = r_overrun;

endmodule

// File: tb/tb_chunk_input_buffer.sv
// tb_chunk_input_buffer: directed bench for the ping-pong input buffer.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_chunk_input_buffer;

   localparam int SW = 24;
   localparam int BS = 4;
   localparam int PB = 2;

   logic          clk;
   logic          rst;
   logic [SW-1:0] in_sample;
   logic          in_valid;
   logic          in_ready;
   logic          chunk_pulse;
   logic          read_bank;
   logic [PB-1:0] input_buff_ptr;
   logic [SW-1:0] input_buff_sample;
   logic          chunk_release;
   logic [15:0]   chunk_count;
   logic          overrun;

   int checks;
   int errors;

   chunk_input_buffer #(
      .SAMPLE_SIZE     (SW),
      .IO_BUFF_SIZE    (BS),
      .IO_BUFF_PTR_BITS(PB)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_sample        (in_sample),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .chunk_pulse      (chunk_pulse),
      .read_bank        (read_bank),
      .input_buff_ptr   (input_buff_ptr),
      .input_buff_sample(input_buff_sample),
      .chunk_release    (chunk_release),
      .chunk_count      (chunk_count),
      .overrun          (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_sample = '0;
      input_buff_ptr = '0;
      chunk_release = 1'b0;
      step();
      step();
      checks++;
      if ({chunk_pulse, read_bank, overrun} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000",
                  {chunk_pulse, read_bank, overrun});
      end
      checks++;
      if (chunk_count !== 16'd0 || input_buff_sample !== 24'd0) begin
         errors++;
         $display("FAIL reset_data got cnt=%h smp=%h want 0/0",
                  chunk_count, input_buff_sample);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %b want 0", in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b want 1", in_ready);
      end
   endtask

   // Streams four samples back to back, checking no early pulse.
   task automatic stream4(input logic [SW-1:0] base, input string tag);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_sample = base + SW'(i);
         step();
         checks++;
         if (chunk_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_pulse[%0d] got %b want 0",
                     tag, i, chunk_pulse);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic read_check(input logic [PB-1:0] p,
                             input logic [SW-1:0] exp,
                             input string tag);
      input_buff_ptr = p;
      step();
      checks++;
      if (input_buff_sample !== exp) begin
         errors++;
         $display("FAIL %s_read[%0d] got %h want %h",
                  tag, p, input_buff_sample, exp);
      end
   endtask

   task automatic expect_pulse(input logic bank,
                               input logic [15:0] cnt,
                               input string tag);
      checks++;
      if (chunk_pulse !== 1'b1 || read_bank !== bank ||
          chunk_count !== cnt) begin
         errors++;
         $display("FAIL %s_pulse got p=%b b=%b c=%0d want 1/%b/%0d",
                  tag, chunk_pulse, read_bank, chunk_count, bank, cnt);
      end
      step();
      checks++;
      if (chunk_pulse !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse_width got %b want 0", tag, chunk_pulse);
      end
   endtask

   task automatic test_basic();
      stream4(24'h000001, "basic");
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready_bank1 got %b want 1", in_ready);
      end
      step();
      expect_pulse(1'b0, 16'd1, "basic");
      for (int p = 0; p < 4; p++) begin
         read_check(PB'(p), SW'(p + 1), "basic");
      end
   endtask

   task automatic test_pingpong();
      stream4(24'h000010, "pp");
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL pp_ready_full got %b want 0", in_ready);
      end
      step();
      checks++;
      if (chunk_pulse !== 1'b0 || chunk_count !== 16'd1) begin
         errors++;
         $display("FAIL pp_no_pulse got p=%b c=%0d want 0/1",
                  chunk_pulse, chunk_count);
      end
   endtask

   task automatic test_overrun();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_pre got %b want 0", overrun);
      end
      in_valid = 1'b1;
      in_sample = 24'hABCDEF;
      step();
      in_valid = 1'b0;
      checks++;
      if (overrun !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL overrun_set got ovr=%b rdy=%b want 1/0",
                  overrun, in_ready);
      end
   endtask

   task automatic test_release();
      chunk_release = 1'b1;
      step();
      chunk_release = 1'b0;
      checks++;
      if (chunk_pulse !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rel_edge got p=%b rdy=%b want 0/1",
                  chunk_pulse, in_ready);
      end
      step();
      expect_pulse(1'b1, 16'd2, "rel");
      read_check(2'd0, 24'h000010, "rel");
      read_check(2'd3, 24'h000013, "rel");
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_sample = 24'h000020 + SW'(i);
         chunk_release = (i == 3);
         step();
      end
      in_valid = 1'b0;
      chunk_release = 1'b0;
      checks++;
      if (chunk_pulse !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL sim_edge got p=%b rdy=%b want 0/1",
                  chunk_pulse, in_ready);
      end
      step();
      expect_pulse(1'b0, 16'd3, "sim");
      step();
      checks++;
      if (chunk_pulse !== 1'b0 || chunk_count !== 16'd3) begin
         errors++;
         $display("FAIL sim_dup got p=%b c=%0d want 0/3",
                  chunk_pulse, chunk_count);
      end
      for (int p = 0; p < 4; p++) begin
         read_check(PB'(p), 24'h000020 + SW'(p), "sim");
      end
   endtask

   task automatic test_spurious();
      chunk_release = 1'b1;
      step();
      chunk_release = 1'b0;
      step();
      chunk_release = 1'b1;
      step();
      chunk_release = 1'b0;
      checks++;
      if (chunk_pulse !== 1'b0 || in_ready !== 1'b1 ||
          chunk_count !== 16'd3 || read_bank !== 1'b0) begin
         errors++;
         $display("FAIL spur_state got p=%b r=%b c=%0d b=%b want 0/1/3/0",
                  chunk_pulse, in_ready, chunk_count, read_bank);
      end
      step();
      checks++;
      if (chunk_pulse !== 1'b0) begin
         errors++;
         $display("FAIL spur_pulse got %b want 0", chunk_pulse);
      end
      stream4(24'h000040, "spur");
      step();
      expect_pulse(1'b1, 16'd4, "spur");
      read_check(2'd2, 24'h000042, "spur");
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_sample = 24'h000050 + SW'(i);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      checks++;
      if ({chunk_pulse, read_bank, overrun, in_ready} !== 4'b0000 ||
          chunk_count !== 16'd0 || input_buff_sample !== 24'd0) begin
         errors++;
         $display("FAIL mrst_vals got p%b b%b o%b r%b c%0d s%h want zeros",
                  chunk_pulse, read_bank, overrun, in_ready,
                  chunk_count, input_buff_sample);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mrst_ready got %b want 1", in_ready);
      end
      step();
      step();
      checks++;
      if (chunk_pulse !== 1'b0 || chunk_count !== 16'd0) begin
         errors++;
         $display("FAIL mrst_stale got p=%b c=%0d want 0/0",
                  chunk_pulse, chunk_count);
      end
      stream4(24'h000030, "mrst");
      step();
      expect_pulse(1'b0, 16'd1, "mrst");
      read_check(2'd0, 24'h000030, "mrst");
      read_check(2'd3, 24'h000033, "mrst");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_pingpong();
      test_overrun();
      test_release();
      test_simultaneous();
      test_spurious();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
